mpool_sched: RTL and testbench

- Sequencer that time-shares one combinational max tree (2^LEVELS leaves) across a pooling window longer than the tree width.
- Accepts a stream of tree-width beats and drives each accepted beat into the external tree. Folds the tree result into a running max.
- Emits one result per window of cfg_beats beats over a valid/ready output.
- Sits between the feature-map buffer and the pooling output FIFO.

---
 rtl/mpool_sched_if.sv | 30 +++
 rtl/mpool_sched.sv | 86 ++++++++
 tb/tb_mpool_sched.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mpool_sched_if.sv
// Handshake and tree bundle for mpool_sched.
// The slave side is the scheduler; the master side is the buffer, the tree and the output FIFO.
interface mpool_sched_if #(
    parameter int IN_WIDTH  = 8,
    parameter int LEVELS    = 2,
    parameter int CNT_WIDTH = 8
);
    localparam int N = 1 << LEVELS;

    logic [CNT_WIDTH-1:0]  cfg_beats;
    logic                  in_valid;
    logic                  in_ready;
    logic [N*IN_WIDTH-1:0] in_data;
    logic [N*IN_WIDTH-1:0] tree_in;
    logic [IN_WIDTH-1:0]   tree_out;
    logic                  out_valid;
    logic                  out_ready;
    logic [IN_WIDTH-1:0]   out_data;
    logic                  busy;

    modport slave (
        input  cfg_beats, in_valid, in_data, tree_out, out_ready,
        output in_ready, tree_in, out_valid, out_data, busy
    );

    modport master (
        output cfg_beats, in_valid, in_data, tree_out, out_ready,
        input  in_ready, tree_in, out_valid, out_data, busy
    );
endinterface

// File: rtl/mpool_sched.sv
// Time-shares one external combinational max tree across a pooling window of cfg_beats beats,
// folding each tree result into a running max and emitting one registered result per window.
//
// state | meaning
// IDLE  | no window open, waiting for the first beat
// ACCUM | window open, folding tree results into acc_q
// HOLD  | result presented on out_data, waiting for out_ready
module mpool_sched #(
    parameter int IN_WIDTH  = 8,
    parameter int LEVELS    = 2,
    parameter int CNT_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mpool_sched_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t               state_q;
    logic [IN_WIDTH-1:0]  acc_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] beats_lat_q;
    logic                 out_valid_q;
    logic [IN_WIDTH-1:0]  out_data_q;

    logic                 accept;
    logic [IN_WIDTH-1:0]  fold_d;
    logic [CNT_WIDTH-1:0] cfg_eff;

    // HOLD only blocks input while the consumer stalls, so a new window can start on the handoff cycle.
    assign bus.in_ready  = (state_q != HOLD) || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.tree_in   = bus.in_data;
    assign fold_d        = (bus.tree_out > acc_q) ? bus.tree_out : acc_q;
    assign cfg_eff       = (bus.cfg_beats == '0) ? CNT_WIDTH'(1) : bus.cfg_beats;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            beats_lat_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE, HOLD: begin
                    if (accept) begin
                        beats_lat_q <= cfg_eff;
                        if (cfg_eff == CNT_WIDTH'(1)) begin
                            out_data_q  <= bus.tree_out;
                            out_valid_q <= 1'b1;
                            state_q     <= HOLD;
                        end else begin
                            acc_q       <= bus.tree_out;
                            cnt_q       <= CNT_WIDTH'(1);
                            out_valid_q <= 1'b0;
                            state_q     <= ACCUM;
                        end
                    end else if ((state_q == HOLD) && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_q <= fold_d;
                        if (cnt_q == beats_lat_q - CNT_WIDTH'(1)) begin
                            out_data_q  <= fold_d;
                            out_valid_q <= 1'b1;
                            cnt_q       <= '0;
                            state_q     <= HOLD;
                        end else begin
                            cnt_q <= cnt_q + CNT_WIDTH'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mpool_sched.sv
// Bench for mpool_sched: directed vector table, hand-written corner sequences and a random run
// against a window-level reference model. The max tree is modelled here as a plain function.
module tb_mpool_sched;
    localparam int IN_WIDTH  = 8;
    localparam int LEVELS    = 2;
    localparam int CNT_WIDTH = 8;
    localparam int N         = 1 << LEVELS;

    logic clk;
    logic rst_n;

    mpool_sched_if #(.IN_WIDTH(IN_WIDTH), .LEVELS(LEVELS), .CNT_WIDTH(CNT_WIDTH)) bus ();

    mpool_sched #(.IN_WIDTH(IN_WIDTH), .LEVELS(LEVELS), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int maxof(input logic [N*IN_WIDTH-1:0] d);
        int m;
        m = 0;
        for (int k = 0; k < N; k++)
            if (int'(d[k*IN_WIDTH +: IN_WIDTH]) > m) m = int'(d[k*IN_WIDTH +: IN_WIDTH]);
        return m;
    endfunction

    assign bus.tree_out = IN_WIDTH'(maxof(bus.tree_in));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a window is a count of beats and the max over every element seen.
    logic m_valid;
    int   m_data;
    int   m_len;
    int   m_cnt;
    int   m_max;

    task automatic model_reset();
        m_valid = 1'b0; m_data = 0; m_len = 0; m_cnt = 0; m_max = 0;
    endtask

    task automatic model_step(input logic acc, input logic [31:0] d, input logic [7:0] cfg,
                              input logic ordy);
        if (m_valid && ordy) m_valid = 1'b0;
        if (acc) begin
            if (m_cnt == 0) begin
                m_len = (cfg == 0) ? 1 : int'(cfg);
                m_max = 0;
            end
            if (maxof(d) > m_max) m_max = maxof(d);
            m_cnt++;
            if (m_cnt == m_len) begin
                m_valid = 1'b1;
                m_data  = m_max;
                m_cnt   = 0;
            end
        end
    endtask

    // Called just after a rising edge; returns once the next edge has been absorbed.
    task automatic cycle(input logic v, input logic [31:0] d, input logic [7:0] cfg,
                         input logic ordy, output logic rdy_s);
        logic acc;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.cfg_beats = cfg;
        bus.out_ready = ordy;
        #1;
        rdy_s = bus.in_ready;
        chk("in_ready", {31'd0, rdy_s}, {31'd0, (!m_valid) || ordy});
        chk("tree_in", bus.tree_in, d);
        acc = v && ((!m_valid) || ordy);
        @(posedge clk);
        model_step(acc, d, cfg, ordy);
        #1;
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        chk("out_data", {24'd0, bus.out_data}, m_data);
        chk("busy", {31'd0, bus.busy}, {31'd0, m_valid || (m_cnt != 0)});
    endtask

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [7:0]  cfg;
        logic        ordy;
        logic        e_rdy;
        logic        e_vld;
        logic [7:0]  e_dat;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic [31:0] d, input logic [7:0] cfg, input logic ordy,
                       input logic e_rdy, input logic e_vld, input logic [7:0] e_dat);
        vec_t t;
        t.v = v; t.d = d; t.cfg = cfg; t.ordy = ordy;
        t.e_rdy = e_rdy; t.e_vld = e_vld; t.e_dat = e_dat;
        tbl.push_back(t);
    endtask

    initial begin
        logic        r;
        logic [31:0] d;
        int          lmax;

        // single beat, cfg 1
        add(1, {8'd9, 8'd37, 8'd42, 8'd65}, 1, 1, 1, 1, 65);
        add(0, 32'd0, 1, 1, 1, 0, 65);
        // three-beat window
        add(1, {8'd4, 8'd3, 8'd2, 8'd1}, 3, 1, 1, 0, 65);
        add(1, {8'd0, 8'd0, 8'd0, 8'd200}, 3, 1, 1, 0, 65);
        add(1, {8'd7, 8'd7, 8'd7, 8'd7}, 3, 1, 1, 1, 200);
        // backpressure, then same-cycle handoff into a new 3-beat window
        for (int i = 0; i < 4; i++) add(1, {4{8'd9}}, 3, 0, 0, 1, 200);
        add(1, {4{8'd9}}, 3, 1, 1, 0, 200);
        add(1, {4{8'd9}}, 3, 1, 1, 0, 200);
        add(1, {4{8'd9}}, 3, 1, 1, 1, 9);
        // extremes and cfg 0 treated as 1 (back-to-back into HOLD)
        add(1, {4{8'h00}}, 2, 1, 1, 0, 9);
        add(1, {4{8'hFF}}, 2, 1, 1, 1, 8'hFF);
        add(1, {4{8'h00}}, 0, 1, 1, 1, 8'h00);
        add(0, 32'd0, 0, 1, 1, 0, 8'h00);
        // cfg change mid-window ignored
        add(1, {8'd40, 8'd30, 8'd20, 8'd10}, 3, 1, 1, 0, 0);
        add(1, {8'd0, 8'd0, 8'd0, 8'd50}, 1, 1, 1, 0, 0);
        add(1, {8'd5, 8'd5, 8'd5, 8'd5}, 1, 1, 1, 1, 50);
        add(0, 32'd0, 1, 1, 1, 0, 50);

        bus.in_valid = 0; bus.in_data = '0; bus.cfg_beats = '0; bus.out_ready = 0;
        rst_n = 1'b0;
        model_reset();
        #3;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, bus.out_data}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].cfg, tbl[i].ordy, r);
            chk($sformatf("vec%0d_rdy", i), {31'd0, r}, {31'd0, tbl[i].e_rdy});
            chk($sformatf("vec%0d_vld", i), {31'd0, bus.out_valid}, {31'd0, tbl[i].e_vld});
            chk($sformatf("vec%0d_dat", i), {24'd0, bus.out_data}, {24'd0, tbl[i].e_dat});
        end

        // mid-window asynchronous reset discards the partial max
        cycle(1, {8'd0, 8'd0, 8'd0, 8'd250}, 2, 1, r);
        bus.in_valid = 0;
        rst_n = 1'b0;
        #2;
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        model_reset();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        cycle(1, {8'd1, 8'd1, 8'd1, 8'd5}, 2, 1, r);
        cycle(1, {8'd2, 8'd2, 8'd2, 8'd2}, 2, 1, r);
        chk("postrst_vld", {31'd0, bus.out_valid}, 32'd1);
        chk("postrst_dat", {24'd0, bus.out_data}, 32'd5);
        cycle(0, 32'd0, 2, 1, r);

        // longest window the counter supports, cfg scrambled after the first beat
        lmax = 0;
        for (int i = 0; i < 255; i++) begin
            d = (i == 137) ? {8'd3, 8'd241, 8'd3, 8'd3} : ($urandom & 32'h7F7F7F7F);
            if (maxof(d) > lmax) lmax = maxof(d);
            cycle(1, d, (i == 0) ? 8'd255 : 8'($urandom_range(0, 255)), 1, r);
            if (i == 253) chk("long_no_early", {31'd0, bus.out_valid}, 32'd0);
        end
        chk("long_vld", {31'd0, bus.out_valid}, 32'd1);
        chk("long_dat", {24'd0, bus.out_data}, lmax);
        cycle(0, 32'd0, 0, 1, r);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, 8'($urandom_range(0, 5)),
                  $urandom_range(0, 3) != 0, r);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
